// File: rtl/store_buffer_pkg.sv
// Shared defaults and entry layout for the MEM-stage store buffer.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;

  // One buffered store: word address only, byte lanes qualified by be.
  typedef struct packed {
    logic                valid;
    logic [SB_AW-1:2]    addr;
    logic [SB_DW-1:0]    data;
    logic [3:0]          be;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding: word-address match against every valid entry,
// youngest match wins; full-word match forwards, partial match stalls.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic                       ld_valid,
  input  logic [AW-1:2]              ld_word,
  output logic                       ld_hit,
  output logic                       ld_stall,
  output logic [DW-1:0]              ld_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic            match;
  sb_entry_t       sel;
  logic [PW-1:0]   idx;

  // Walk slots oldest to youngest from head so the last match is the youngest.
  always_comb begin
    match = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (entries[idx].valid && (entries[idx].addr == ld_word)) begin
        match = 1'b1;
        sel   = entries[idx];
      end
    end
  end

  // Resolve the selected entry into hit / stall / forwarded data.
  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if (ld_valid && match) begin
      if (sel.be == 4'hF) begin
        ld_hit  = 1'b1;
        ld_data = sel.data;
      end else begin
        ld_stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular-FIFO store buffer between the MEM stage and data memory.
// State updates on the falling clock edge to line up with the pipeline.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  input  logic [3:0]                 st_be,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data,
  output logic                       ld_stall,
  output logic                       dm_we,
  output logic [AW-1:0]              dm_addr,
  output logic [DW-1:0]              dm_wdata,
  output logic [3:0]                 dm_be,
  input  logic                       dm_ack,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t       entries [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic            push;
  logic            pop;
  logic            unused_lsbs;

  assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  // Full blocks a push even when a pop lands on the same edge.
  assign st_ready = (count_q < CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push     = st_valid && st_ready;
  assign dm_we    = !empty;
  assign pop      = dm_we && dm_ack;

  // Head entry drives memory directly; zeroed while nothing is pending.
  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = '0;
    if (dm_we) begin
      dm_addr  = {entries[head].addr, 2'b00};
      dm_wdata = entries[head].data;
      dm_be    = entries[head].be;
    end
  end

  // FIFO pointers, occupancy and entry storage; reset discards everything.
  always_ff @(negedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      if (push) begin
        entries[tail] <= '{valid: 1'b1, addr: st_addr[AW-1:2],
                           data: st_data, be: st_be};
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  store_buffer_fwd #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .entries  (entries),
    .head     (head),
    .ld_valid (ld_valid),
    .ld_word  (ld_addr[AW-1:2]),
    .ld_hit   (ld_hit),
    .ld_stall (ld_stall),
    .ld_data  (ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: inputs change on the rising edge, the
// DUT updates on the falling edge, the scoreboard samples 2ns after rising.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b1;
  logic          reset = 1'b1;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic [3:0]    st_be = '0;
  logic          st_ready;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          ld_stall;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_be;
  logic          dm_ack = 1'b0;
  logic [2:0]    count;
  logic          empty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t q[$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_be    (st_be),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .ld_stall (ld_stall),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_be    (dm_be),
    .dm_ack   (dm_ack),
    .count    (count),
    .empty    (empty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic [3:0] sbe,
                       input logic ack, input logic lv, input logic [31:0] la);
    @(posedge clk);
    reset    = rst;
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    st_be    = sbe;
    dm_ack   = ack;
    ld_valid = lv;
    ld_addr  = la;
  endtask

  // Scoreboard: compare outputs with the queue model, then apply this cycle's
  // reset / drain / accept to the model exactly as the next edge will.
  initial begin
    logic        e_hit, e_stall, found;
    logic [31:0] e_data;
    int          pre;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #2;
      check("dm_we", dm_we, q.size() > 0);
      check("count", count, q.size());
      check("st_ready", st_ready, q.size() < DEPTH);
      check("empty", empty, q.size() == 0);
      if (q.size() > 0) begin
        check("dm_addr", dm_addr, {q[0].addr[31:2], 2'b00});
        check("dm_wdata", dm_wdata, q[0].data);
        check("dm_be", dm_be, q[0].be);
      end else begin
        check("dm_addr_idle", dm_addr, 0);
        check("dm_wdata_idle", dm_wdata, 0);
        check("dm_be_idle", dm_be, 0);
      end
      e_hit = 0; e_stall = 0; e_data = 0; found = 0;
      if (ld_valid) begin
        for (int i = q.size() - 1; i >= 0 && !found; i--) begin
          if (q[i].addr[31:2] == ld_addr[31:2]) begin
            found = 1;
            if (q[i].be == 4'hF) begin
              e_hit = 1; e_data = q[i].data;
            end else begin
              e_stall = 1;
            end
          end
        end
      end
      check("ld_hit", ld_hit, e_hit);
      check("ld_stall", ld_stall, e_stall);
      if (!e_stall) check("ld_data", ld_data, e_data);

      pre = q.size();
      if (reset) begin
        q.delete();
      end else begin
        if (pre > 0 && dm_ack) void'(q.pop_front());
        if (st_valid && pre < DEPTH) q.push_back('{addr: st_addr, data: st_data, be: st_be});
      end
    end
  end

  initial begin
    logic [3:0] be;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0);
    // single store drains the cycle it is acknowledged
    drive(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 1, 32'h100);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h101);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // fill, overflow attempt, one drain
    for (int i = 0; i < 4; i++) drive(0, 1, 32'h40 + 4 * i, 32'hA0 + i, 4'hF, 0, 0, 0);
    drive(0, 1, 32'h80, 32'hBAD, 4'hF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h44);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
    // youngest full-word match forwards
    drive(0, 1, 32'h200, 32'h11111111, 4'hF, 0, 0, 0);
    drive(0, 1, 32'h200, 32'h22222222, 4'hF, 0, 1, 32'h202);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h202);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h202);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h202);
    // partial store stalls the load until drained
    drive(0, 1, 32'h300, 32'hAABBCCDD, 4'b0011, 0, 1, 32'h300);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h300);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h300);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h300);
    // zero-enable store still drains and never hits
    drive(0, 1, 32'h500, 32'h55, 4'h0, 0, 1, 32'h500);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h500);
    // full + simultaneous push/pop, then refill across pointer wrap
    for (int i = 0; i < 4; i++) drive(0, 1, 32'h600 + 4 * i, 32'hC0 + i, 4'hF, 0, 0, 0);
    drive(0, 1, 32'h700, 32'hD0, 4'hF, 1, 0, 0);
    drive(0, 1, 32'h704, 32'hD1, 4'hF, 0, 1, 32'h704);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
    // reset mid-drain discards pending stores
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h800 + 4 * i, 32'hE0 + i, 4'hF, 0, 0, 0);
    drive(1, 1, 32'h900, 32'hF0, 4'hF, 1, 1, 32'h800);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 1, 32'h800);
    // randomized traffic over a small address window
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0: be = 4'h0;
        1: be = 4'(($urandom_range(0, 14)));
        default: be = 4'hF;
      endcase
      drive(($urandom_range(0, 99) == 0),
            $urandom_range(0, 1),
            32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3),
            $urandom, be,
            ($urandom_range(0, 2) != 0),
            $urandom_range(0, 1),
            32'h1000 + ($urandom_range(0, 4) << 2) + $urandom_range(0, 3));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, at least 2.
REQ-002 Parameter AW, default 32, byte-address width.
REQ-003 Parameter DW, default 32, data width; fixed at 32 (4 byte lanes).
REQ-004 clk  in  1  clock; all state SHALL update on the falling edge, matching the pipeline registers.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 st_valid  in  1  MEM-stage store request.
REQ-007 st_addr  in  AW  store byte address; bits [1:0] ignored (word granularity).
REQ-008 st_data  in  DW  store data, lane-aligned.
REQ-009 st_be  in  4  byte enables; bit i enables byte lane i.
REQ-010 st_ready  out  1  buffer can accept a store this cycle.
REQ-011 ld_valid  in  1  MEM-stage load lookup.
REQ-012 ld_addr  in  AW  load byte address; bits [1:0] ignored.
REQ-013 ld_hit  out  1  load fully forwarded from the buffer.
REQ-014 ld_data  out  DW  forwarded word; valid only when ld_hit=1.
REQ-015 ld_stall  out  1  partial overlap; load must wait for drain.
REQ-016 dm_we  out  1  write request to data memory.
REQ-017 dm_addr / dm_wdata / dm_be  out  AW / DW / 4  head-entry address (bits [1:0] = 0), data, and byte enables.
REQ-018 dm_ack  in  1  data memory accepted the current write.
REQ-019 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-020 empty  out  1  count==0.

Function
REQ-021 Entries SHALL be held in a circular FIFO with head and tail pointers; both pointers wrap modulo DEPTH.
REQ-022 st_ready SHALL be count<DEPTH; a store is pushed at the edge where st_valid and st_ready are both 1.
REQ-023 When full, a pop on the same edge SHALL NOT admit a push; st_ready stays 0 throughout that cycle.
REQ-024 dm_we SHALL equal !empty; dm_addr, dm_wdata, and dm_be SHALL come directly from the head entry with no additional register stage.
REQ-025 A pop SHALL occur at the edge where dm_we and dm_ack are both 1; dm_ack while empty is ignored.
REQ-026 A push and a pop on the same edge SHALL leave count unchanged and advance both pointers.
REQ-027 A store pushed at edge N SHALL appear on dm_we at edge N if the buffer was empty; otherwise it appears in FIFO order.
REQ-028 ld_addr[AW-1:2] SHALL be compared against every valid entry; the youngest matching entry is selected.
REQ-029 If the selected entry has be==4'hF, the block SHALL drive ld_hit=1 and ld_data=entry data in the same cycle (combinational).
REQ-030 If any entry matches but the youngest has be!=4'hF, the block SHALL drive ld_stall=1 and ld_hit=0.
REQ-031 With no match or ld_valid=0, ld_hit=0, ld_stall=0, and ld_data=0.
REQ-032 The lookup SHALL see only stored entries; a store pushed on the same edge is not visible to the load in that cycle.
REQ-033 An entry with st_be=4'h0 SHALL still be pushed and drained, and it never produces ld_hit.

Reset
REQ-034 Reset SHALL force head=0, tail=0, count=0, and all entry valid bits to 0.
REQ-035 After reset, outputs SHALL be: dm_we=0, dm_addr=0, dm_wdata=0, dm_be=0, st_ready=1, empty=1, ld_hit=0, ld_stall=0, ld_data=0.
REQ-036 Reset in mid-drain SHALL discard all pending stores; dm_ack on the reset edge is ignored.
REQ-037 Reset SHALL take priority over simultaneous push and pop.

Structure
REQ-038 A shared package SHALL hold DEPTH/AW/DW defaults and the entry typedef {valid, addr[AW-1:2], data, be}.
REQ-039 Address match and youngest-entry priority selection SHALL be a sub-module store_buffer_fwd; FIFO control stays in store_buffer.

Verification
REQ-040 Push {0x100, 0xDEADBEEF, F} on an empty buffer -> dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF the same cycle; dm_ack -> empty=1.
REQ-041 Push 4 stores with dm_ack=0 -> count=4, st_ready=0; a 5th st_valid is not accepted; one dm_ack -> count=3, st_ready=1.
REQ-042 Push {0x200, 0x11111111, F} then {0x200, 0x22222222, F}; load 0x202 -> ld_hit=1, ld_data=0x22222222.
REQ-043 Push {0x300, 0xAABBCCDD, 4'b0011}; load 0x300 -> ld_stall=1, ld_hit=0; after drain -> ld_stall=0.
REQ-044 With the buffer full, assert st_valid and dm_ack together -> count drops to 3, no push; next cycle push accepted, count=4; FIFO order held across pointer wrap.
REQ-045 3 entries pending, assert reset during dm_ack -> next cycle count=0, dm_we=0, and none of the 3 stores is ever re-issued.
